nios_led_pio_in: RTL and testbench
==================================

NIOS_LED_PIO_IN -- requirements
Module: nios_led_pio_in

Interface
REQ-001 Parameter WIDTH, default 8: input port width, 1..32.
REQ-002 Parameter EDGE_TYPE, default 0: capture edge, 0 rising, 1 falling, 2 any.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset; synchronous, active-high.
REQ-005 address  input  2  Avalon-MM word address.
REQ-006 chipselect  input  1  slave select.
REQ-007 read_n  input  1  active-low read strobe, qualified by chipselect.
REQ-008 write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-009 writedata  input  32  write data.
REQ-010 in_port  input  WIDTH  asynchronous external inputs (buttons/switches).
REQ-011 readdata  output  32  registered read data.
REQ-012 irq  output  1  level interrupt to the Nios II core.

Function
REQ-013 Register map: 0 DATA (RO, synchronized in_port), 1 reserved (reads 0, writes ignored), 2 IRQMASK (RW, WIDTH bits), 3 EDGECAP (read; write-1-to-clear per bit).
REQ-014 in_port passes through a 2-flop synchronizer; the value after the second flop is sync_in; DATA reads sync_in.
REQ-015 A third register prev_in holds the prior sync_in; edge[i] = rising (sync_in & ~prev_in), falling (~sync_in & prev_in) or any (sync_in ^ prev_in) per EDGE_TYPE.
REQ-016 An edge sets EDGECAP[i] on the next clock; the bit stays set until cleared by software.
REQ-017 A write to address 3 clears every EDGECAP bit where writedata[i]=1; other bits are unchanged.
REQ-018 Same-cycle edge and clear on one bit: set wins, so the bit remains 1.
REQ-019 A write to address 2 loads IRQMASK <= writedata[WIDTH-1:0].
REQ-020 irq = OR of (EDGECAP & IRQMASK), driven from registers with no combinational path from bus inputs.
REQ-021 Read latency is fixed at 1 cycle. A read at cycle N (chipselect & ~read_n) presents the zero-extended register on readdata at N+1.
REQ-022 readdata holds its last value when no read occurs; unused upper bits are always 0.
REQ-023 Reads have no side effects, including reads of EDGECAP.
REQ-024 An edge-detect blanking counter (2 bits) suppresses edge capture for the first 3 cycles after reset deasserts, so pins already high at reset release cause no false edge.
REQ-025 Writes to address 0 or 1 are ignored.

Reset
REQ-026 While reset=1 at a clock edge: synchronizer flops, prev_in, EDGECAP, IRQMASK and readdata go to 0, and the blanking counter loads 3.
REQ-027 irq is 0 during reset and on the first cycle after it.
REQ-028 Reset asserted mid-transaction aborts the transaction; a read in the reset cycle returns 0.

Structure
REQ-029 Shared package nios_led_pio_pkg holds the address constants (ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3) and the EDGE_TYPE encodings.
REQ-030 The synchronizer is one sub-module, nios_led_pio_sync (parameter WIDTH, 2 stages, synchronous reset to 0).
REQ-031 Estimated size is 120-250 lines of RTL, with no latches and no clock gating.

Verification
REQ-032 Reset, then hold in_port=8'hFF from reset release. Required: EDGECAP read = 8'h00, DATA read = 8'hFF after 3 cycles, irq=0.
REQ-033 EDGE_TYPE=0, IRQMASK=8'h01, in_port bit0 0->1. Required: EDGECAP=8'h01 and irq=1 no later than 4 cycles after the pin change. Then write 8'h01 to address 3. Required: EDGECAP=0 and irq=0 next cycle.
REQ-034 Rising edge on bit3 in the same cycle as a write of 8'h08 to address 3. Required: EDGECAP[3]=1 afterwards.
REQ-035 IRQMASK=8'h00 with edges on bits 0..7. Required: EDGECAP=8'hFF, irq=0. Then write IRQMASK=8'h80. Required: irq=1 next cycle.
REQ-036 Back-to-back reads of addresses 0, 2, 3, 1. Required: each readdata valid exactly one cycle after its read, and the address-1 read returns 32'h0.
REQ-037 Reset asserted while EDGECAP=8'h5A and IRQMASK=8'hFF. Required: both registers = 0 and irq=0 on the cycle after reset.

Source files
------------

// File: rtl/nios_led_pio_pkg.sv
// Shared constants for the LED/button PIO input block: register map and
// edge-capture mode encodings.
package nios_led_pio_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_RSVD    = 2'd1,
    ADDR_IRQMASK = 2'd2,
    ADDR_EDGECAP = 2'd3
  } pio_addr_e;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Cycles after reset release during which edge capture is held off.
  localparam logic [1:0] BLANK_CYCLES = 2'd3;

endpackage

// File: rtl/nios_led_pio_sync.sv
// Two-stage synchronizer bringing asynchronous pin levels into clk.
// Both stages clear synchronously on reset.
module nios_led_pio_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nios_led_pio_in.sv
// Avalon-MM PIO input port with per-bit edge capture, interrupt mask and a
// short post-reset blanking window so already-asserted pins raise no edge.
module nios_led_pio_in
  import nios_led_pio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] prev_in;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] clr_vec;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] irq_mask;
  logic [1:0]       blank_cnt;
  logic             capture_en;
  logic             rd_en;
  logic             wr_en;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  // Upper writedata bits beyond WIDTH carry no meaning.
  assign unused_wdata = ^writedata;

  nios_led_pio_sync #(.WIDTH(WIDTH)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in_port),
    .q     (sync_in)
  );

  assign rd_en      = chipselect & ~read_n;
  assign wr_en      = chipselect & ~write_n;
  assign capture_en = (blank_cnt == 2'd0);

  always_comb begin
    edge_vec = '0;
    case (EDGE_TYPE)
      EDGE_FALLING: edge_vec = ~sync_in & prev_in;
      EDGE_ANY:     edge_vec = sync_in ^ prev_in;
      default:      edge_vec = sync_in & ~prev_in;
    endcase
  end

  always_comb begin
    clr_vec = '0;
    if (wr_en && (address == ADDR_EDGECAP))
      clr_vec = writedata[WIDTH-1:0];
  end

  always_comb begin
    rd_mux = '0;
    case (pio_addr_e'(address))
      ADDR_DATA:    rd_mux[WIDTH-1:0] = sync_in;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edge_cap;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_in   <= '0;
      edge_cap  <= '0;
      irq_mask  <= '0;
      readdata  <= '0;
      blank_cnt <= BLANK_CYCLES;
    end else begin
      prev_in <= sync_in;
      if (blank_cnt != 2'd0)
        blank_cnt <= blank_cnt - 2'd1;
      // A new edge wins over a same-cycle software clear of that bit.
      edge_cap <= (edge_cap & ~clr_vec) | (capture_en ? edge_vec : '0);
      if (wr_en && (address == ADDR_IRQMASK))
        irq_mask <= writedata[WIDTH-1:0];
      if (rd_en)
        readdata <= rd_mux;
    end
  end

  // Purely from registers; bus inputs reach irq only through a clock edge.
  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_nios_led_pio_in.sv
// Bench for nios_led_pio_in (WIDTH=8, rising edges): a fixed vector table,
// hand sequences for same-cycle set/clear and reset, then random traffic.
module tb_nios_led_pio_in;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  nios_led_pio_in #(.WIDTH(8), .EDGE_TYPE(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] OP_IDLE = 2'd0, OP_RD = 2'd1, OP_WR = 2'd2, OP_NOCS = 2'd3;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: pin samples since reset release, indexed by edge number.
  logic [7:0]  hist[$];
  int          k;
  logic [7:0]  m_ec;
  logic [7:0]  m_mask;
  logic [31:0] m_rd;
  logic        m_irq;

  function automatic logic [7:0] s_at(int j);
    if (j < 1 || j > hist.size()) return 8'h00;
    return hist[j-1];
  endfunction

  task automatic model_edge(input logic rst, input logic [1:0] op, input logic [1:0] a,
                            input logic [31:0] wd, input logic [7:0] pin);
    int         kn;
    logic [7:0] sy;
    logic [7:0] pv;
    logic [7:0] clr;
    if (rst) begin
      hist.delete();
      k      = 0;
      m_ec   = 8'h00;
      m_mask = 8'h00;
      m_rd   = 32'h0;
    end else begin
      kn = k + 1;
      sy = s_at(kn - 2);
      pv = s_at(kn - 3);
      if (op == OP_RD) begin
        case (a)
          2'd0:    m_rd = {24'h0, sy};
          2'd2:    m_rd = {24'h0, m_mask};
          2'd3:    m_rd = {24'h0, m_ec};
          default: m_rd = 32'h0;
        endcase
      end
      clr  = (op == OP_WR && a == 2'd3) ? wd[7:0] : 8'h00;
      m_ec = (m_ec & ~clr) | ((kn >= 4) ? (sy & ~pv) : 8'h00);
      if (op == OP_WR && a == 2'd2) m_mask = wd[7:0];
      hist.push_back(pin);
      k = kn;
    end
    m_irq = |(m_ec & m_mask);
  endtask

  task automatic step(input logic rst, input logic [1:0] op, input logic [1:0] a,
                      input logic [31:0] wd, input logic [7:0] pin);
    reset      = rst;
    chipselect = (op == OP_RD) || (op == OP_WR);
    read_n     = !((op == OP_RD) || (op == OP_NOCS));
    write_n    = !((op == OP_WR) || (op == OP_NOCS));
    address    = a;
    writedata  = wd;
    in_port    = pin;
    @(posedge clk);
    model_edge(rst, op, a, wd, pin);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [7:0]  pin;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  function automatic vec_t mk(logic [1:0] op, logic [1:0] a, logic [31:0] wd,
                              logic [7:0] pin, logic [31:0] exp_rd, logic exp_irq);
    vec_t v;
    v.op = op; v.a = a; v.wd = wd; v.pin = pin; v.exp_rd = exp_rd; v.exp_irq = exp_irq;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [7:0] pin;
    int         r;
    logic [1:0] op;

    // Pins high from reset release: blanking must hide the apparent edge.
    tbl.push_back(mk(OP_IDLE, 2'd0, 32'h0,        8'hFF, 32'h00, 1'b0));
    tbl.push_back(mk(OP_IDLE, 2'd0, 32'h0,        8'hFF, 32'h00, 1'b0));
    tbl.push_back(mk(OP_RD,   2'd3, 32'h0,        8'hFF, 32'h00, 1'b0));
    tbl.push_back(mk(OP_RD,   2'd0, 32'h0,        8'hFF, 32'hFF, 1'b0));
    tbl.push_back(mk(OP_RD,   2'd3, 32'h0,        8'hFF, 32'h00, 1'b0));
    // Mask bit0, pulse bit0 low then high.
    tbl.push_back(mk(OP_WR,   2'd2, 32'h01,       8'hFE, 32'h00, 1'b0));
    tbl.push_back(mk(OP_IDLE, 2'd0, 32'h0,        8'hFE, 32'h00, 1'b0));
    tbl.push_back(mk(OP_IDLE, 2'd0, 32'h0,        8'hFE, 32'h00, 1'b0));
    tbl.push_back(mk(OP_IDLE, 2'd0, 32'h0,        8'hFF, 32'h00, 1'b0));
    tbl.push_back(mk(OP_IDLE, 2'd0, 32'h0,        8'hFF, 32'h00, 1'b0));
    tbl.push_back(mk(OP_IDLE, 2'd0, 32'h0,        8'hFF, 32'h00, 1'b1));
    tbl.push_back(mk(OP_RD,   2'd3, 32'h0,        8'hFF, 32'h01, 1'b1));
    tbl.push_back(mk(OP_WR,   2'd3, 32'h01,       8'hFF, 32'h01, 1'b0));
    tbl.push_back(mk(OP_RD,   2'd3, 32'h0,        8'hFF, 32'h00, 1'b0));
    // Mask off, edges on every bit, then unmask bit7.
    tbl.push_back(mk(OP_WR,   2'd2, 32'h00,       8'hFF, 32'h00, 1'b0));
    tbl.push_back(mk(OP_IDLE, 2'd0, 32'h0,        8'h00, 32'h00, 1'b0));
    tbl.push_back(mk(OP_IDLE, 2'd0, 32'h0,        8'h00, 32'h00, 1'b0));
    tbl.push_back(mk(OP_IDLE, 2'd0, 32'h0,        8'h00, 32'h00, 1'b0));
    tbl.push_back(mk(OP_IDLE, 2'd0, 32'h0,        8'hFF, 32'h00, 1'b0));
    tbl.push_back(mk(OP_IDLE, 2'd0, 32'h0,        8'hFF, 32'h00, 1'b0));
    tbl.push_back(mk(OP_IDLE, 2'd0, 32'h0,        8'hFF, 32'h00, 1'b0));
    tbl.push_back(mk(OP_RD,   2'd3, 32'h0,        8'hFF, 32'hFF, 1'b0));
    tbl.push_back(mk(OP_WR,   2'd2, 32'h80,       8'hFF, 32'hFF, 1'b1));
    tbl.push_back(mk(OP_RD,   2'd2, 32'h0,        8'hFF, 32'h80, 1'b1));
    // Back-to-back reads 0, 2, 3, 1; writes to 1 and 0 ignored.
    tbl.push_back(mk(OP_RD,   2'd0, 32'h0,        8'hFF, 32'hFF, 1'b1));
    tbl.push_back(mk(OP_RD,   2'd2, 32'h0,        8'hFF, 32'h80, 1'b1));
    tbl.push_back(mk(OP_RD,   2'd3, 32'h0,        8'hFF, 32'hFF, 1'b1));
    tbl.push_back(mk(OP_RD,   2'd1, 32'h0,        8'hFF, 32'h00, 1'b1));
    tbl.push_back(mk(OP_WR,   2'd1, 32'hFFFFFFFF, 8'hFF, 32'h00, 1'b1));
    tbl.push_back(mk(OP_WR,   2'd0, 32'h0,        8'hFF, 32'h00, 1'b1));
    tbl.push_back(mk(OP_RD,   2'd1, 32'h0,        8'hFF, 32'h00, 1'b1));
    tbl.push_back(mk(OP_WR,   2'd3, 32'hFF,       8'hFF, 32'h00, 1'b0));
    tbl.push_back(mk(OP_RD,   2'd3, 32'h0,        8'hFF, 32'h00, 1'b0));
    tbl.push_back(mk(OP_RD,   2'd0, 32'h0,        8'hFF, 32'hFF, 1'b0));

    step(1'b1, OP_IDLE, 2'd0, 32'h0, 8'hFF);
    step(1'b1, OP_IDLE, 2'd0, 32'h0, 8'hFF);
    check("reset_rd", readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(1'b0, tbl[i].op, tbl[i].a, tbl[i].wd, tbl[i].pin);
      check($sformatf("tbl%0d_rd", i), readdata, tbl[i].exp_rd);
      check($sformatf("tbl%0d_irq", i), {31'b0, irq}, {31'b0, tbl[i].exp_irq});
    end

    // Rising edge on bit3 lands in the same cycle as a clear of bit3.
    step(1'b0, OP_IDLE, 2'd0, 32'h0,  8'hF7);
    step(1'b0, OP_IDLE, 2'd0, 32'h0,  8'hF7);
    step(1'b0, OP_IDLE, 2'd0, 32'h0,  8'hF7);
    step(1'b0, OP_IDLE, 2'd0, 32'h0,  8'hFF);
    step(1'b0, OP_IDLE, 2'd0, 32'h0,  8'hFF);
    step(1'b0, OP_WR,   2'd3, 32'h08, 8'hFF);
    step(1'b0, OP_RD,   2'd3, 32'h0,  8'hFF);
    check("set_wins_rd", readdata, 32'h08);
    check("set_wins_irq", {31'b0, irq}, 32'h0);

    // Build EDGECAP=5A with IRQMASK=FF, then reset with a read in flight.
    step(1'b0, OP_WR,   2'd2, 32'hFF, 8'hFF);
    check("mask_ff_irq", {31'b0, irq}, 32'h1);
    step(1'b0, OP_WR,   2'd3, 32'hFF, 8'hA5);
    check("clr_all_irq", {31'b0, irq}, 32'h0);
    step(1'b0, OP_IDLE, 2'd0, 32'h0,  8'hA5);
    step(1'b0, OP_IDLE, 2'd0, 32'h0,  8'hA5);
    step(1'b0, OP_IDLE, 2'd0, 32'h0,  8'hFF);
    step(1'b0, OP_IDLE, 2'd0, 32'h0,  8'hFF);
    step(1'b0, OP_IDLE, 2'd0, 32'h0,  8'hFF);
    step(1'b0, OP_RD,   2'd3, 32'h0,  8'hFF);
    check("pre_reset_ec", readdata, 32'h5A);
    check("pre_reset_irq", {31'b0, irq}, 32'h1);
    step(1'b1, OP_RD,   2'd3, 32'h0,  8'hFF);
    check("reset_cycle_rd", readdata, 32'h0);
    check("reset_cycle_irq", {31'b0, irq}, 32'h0);
    step(1'b0, OP_RD,   2'd3, 32'h0,  8'hFF);
    check("post_reset_ec", readdata, 32'h0);
    check("post_reset_irq", {31'b0, irq}, 32'h0);
    step(1'b0, OP_RD,   2'd2, 32'h0,  8'hFF);
    check("post_reset_mask", readdata, 32'h0);
    step(1'b0, OP_IDLE, 2'd0, 32'h0,  8'hFF);
    step(1'b0, OP_RD,   2'd3, 32'h0,  8'hFF);
    check("post_reset_noedge", readdata, 32'h0);

    // Random traffic against the reference model.
    pin = 8'h00;
    step(1'b1, OP_IDLE, 2'd0, 32'h0, pin);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      op = OP_IDLE;
      else if (r < 6) op = OP_RD;
      else if (r < 9) op = OP_WR;
      else            op = OP_NOCS;
      if ($urandom_range(0, 3) == 0) pin = 8'($urandom);
      step(($urandom_range(0, 127) == 0), op, 2'($urandom), $urandom, pin);
      check($sformatf("rand%0d_rd", i), readdata, m_rd);
      check($sformatf("rand%0d_irq", i), {31'b0, irq}, {31'b0, m_irq});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
